cmp_resp_checker: RTL
=====================

Name: cmp_resp_checker

Overview:
- Hardware response checker for the team's magnitude comparators (e.g. the 2-bit comparator); the receiving end of the operand/result interface that stimulus benches drive.
- Accepts {a, b, eq, gt, lt} tuples over a valid/ready handshake and recomputes the expected result.
- Counts vectors and mismatches, captures the first failing vector, and reports pass/fail once NUM_VEC vectors have been accepted.
- Sits beside any comparator DUT in simulation or on-chip self-test.

Parameters:
- W, 2, operand width in bits.
- NUM_VEC, 16, vectors per run (default = exhaustive 2-bit space, 4x4).
- CW, $clog2(NUM_VEC+1), counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a run.
- in_valid  input  1  tuple on a/b/eq/gt/lt is valid.
- in_ready  output  1  checker accepts a tuple this cycle.
- a  input  W  operand A applied to the DUT.
- b  input  W  operand B applied to the DUT.
- eq  input  1  DUT equal output.
- gt  input  1  DUT greater-than output.
- lt  input  1  DUT less-than output.
- busy  output  1  run in progress.
- done  output  1  run complete (level, held until next start or reset).
- pass  output  1  valid while done; 1 when err_cnt==0.
- vec_cnt  output  CW  vectors accepted this run.
- err_cnt  output  CW  mismatching vectors this run; saturates at all-ones.
- fail_valid  output  1  first-failure capture registers hold data.
- fail_a  output  W  a of first failing vector.
- fail_b  output  W  b of first failing vector.
- fail_flags  output  3  observed {eq,gt,lt} of first failing vector.

Behaviour:
- Clock and reset: single clock domain. rst is synchronous, active-high, and takes priority over all other inputs.
- Reset values: state IDLE; busy, done, pass, in_ready, fail_valid = 0; vec_cnt, err_cnt, fail_a, fail_b, fail_flags = 0.
- State machine: states IDLE, RUN, DONE.
  - IDLE: start -> RUN; counters and capture registers are cleared on the same edge.
  - RUN: in_ready = 1. accept = in_valid & in_ready.
  - DONE: done = 1. start -> RUN with counters and capture registers cleared.
- Expected result: exp = {a==b, a>b, a<b}, unsigned, W-bit compare. Mismatch when {eq,gt,lt} != exp.
- Accept latency: all outputs are registered. An accept updates vec_cnt and err_cnt and the capture registers on the following edge (one-cycle latency).
- First-failure capture: the first mismatch in a run loads fail_a, fail_b and fail_flags and sets fail_valid. Later mismatches do not overwrite the capture.
- Run completion: the accept that brings vec_cnt to NUM_VEC moves the FSM to DONE on that same edge. done=1 and pass=(final err_cnt==0) are visible the next cycle, and pass includes the last vector's result.
- Idle gaps: in_valid=0 gaps during RUN are legal. Counters hold during gaps; there is no timeout.
- Ignored inputs:
  - start while in RUN is ignored.
  - in_valid in IDLE or DONE is ignored; in_ready = 0 in those states.
- Saturation: err_cnt saturates at 2^CW-1 and does not wrap.
- Reset mid-run: the FSM returns to IDLE and all outputs return to their reset values; the partial run is discarded.
- busy = (state==RUN).

Optional Feature:
- Macro name: CMP_ONEHOT_CHECK_EN.
- Macro defined:
  - Adds output onehot_err_cnt [CW], which counts accepted vectors whose {eq,gt,lt} is not exactly one-hot. It is a separate count, also saturating, and cleared with the other counters on start.
  - pass additionally requires onehot_err_cnt==0.
- Macro undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cmp_pkg:
  - state enum: ST_IDLE, ST_RUN, ST_DONE.
  - flag-vector index constants: IDX_EQ=2, IDX_GT=1, IDX_LT=0.
  - function exp_flags(a, b), returning the 3-bit golden vector.
- Sub-module cmp_golden_model (combinational W-bit reference comparator) is natural, so expected-result logic can be reused by other checkers.
- The FSM, counters and capture registers remain in the top module.

Test Plan:
- Exhaustive pass: rst, start, then drive a=0..3 × b=0..3 from a correct comparator with in_valid=1 every cycle -> in_ready high 16 cycles, done=1, pass=1, vec_cnt=16, err_cnt=0, fail_valid=0.
- Injected fault: as above, but force {eq,gt,lt}=001 at a=2, b=1 and 100 at a=3, b=0 -> err_cnt=2, pass=0, fail_a=2'b10, fail_b=2'b01, fail_flags=3'b001.
- Handshake gaps: in_valid toggled 1,0,0,1 randomly over 16 vectors -> vec_cnt increments only on accepts, done exactly one cycle after the 16th accept.
- Control corners:
  - start pulse at vector 5 during RUN -> ignored, vec_cnt continues.
  - rst at vector 9 -> all outputs 0 next cycle, state IDLE.
  - in_valid in IDLE -> no count.
- Restart: after DONE with err_cnt=2, pulse start -> counters, done and fail_valid cleared; a clean 16-vector run gives pass=1.
- CMP_ONEHOT_CHECK_EN defined: drive {eq,gt,lt}=110 at a=1, b=1 -> err_cnt=1, onehot_err_cnt=1, pass=0.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the comparator response checkers:
// FSM state enum, flag-vector bit positions and the golden compare function.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

  localparam int IDX_EQ = 2;
  localparam int IDX_GT = 1;
  localparam int IDX_LT = 0;

  // Operands are passed zero-extended so the compare is unsigned for any W up to 32.
  function automatic logic [2:0] exp_flags(input logic [31:0] a, input logic [31:0] b);
    logic [2:0] f;
    f         = 3'b000;
    f[IDX_EQ] = (a == b);
    f[IDX_GT] = (a > b);
    f[IDX_LT] = (a < b);
    return f;
  endfunction

  function automatic logic is_onehot3(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

endpackage

// File: rtl/cmp_golden_model.sv
// Combinational W-bit reference comparator producing the expected {eq,gt,lt} vector.
module cmp_golden_model
  import cmp_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [2:0]   flags
);

  assign flags = exp_flags(32'(a), 32'(b));

endmodule

// File: rtl/cmp_resp_checker.sv
// Response checker for magnitude comparators: counts vectors and mismatches, captures the
// first failure and reports pass/fail. Optional one-hot check enabled by CMP_ONEHOT_CHECK_EN.
module cmp_resp_checker
  import cmp_pkg::*;
#(
  parameter  int W       = 2,
  parameter  int NUM_VEC = 16,
  localparam int CW      = $clog2(NUM_VEC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          eq,
  input  logic          gt,
  input  logic          lt,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] vec_cnt,
  output logic [CW-1:0] err_cnt,
`ifdef CMP_ONEHOT_CHECK_EN
  output logic [CW-1:0] onehot_err_cnt,
`endif
  output logic          fail_valid,
  output logic [W-1:0]  fail_a,
  output logic [W-1:0]  fail_b,
  output logic [2:0]    fail_flags
);

  cmp_state_e    state_r, state_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          pass_r, pass_s;
  logic          in_ready_r, in_ready_s;
  logic [CW-1:0] vec_cnt_r, vec_cnt_s;
  logic [CW-1:0] err_cnt_r, err_cnt_s;
  logic          fail_valid_r, fail_valid_s;
  logic [W-1:0]  fail_a_r, fail_a_s;
  logic [W-1:0]  fail_b_r, fail_b_s;
  logic [2:0]    fail_flags_r, fail_flags_s;
  logic [2:0]    exp_s;
  logic [2:0]    obs_s;
  logic          accept_s;
  logic          mismatch_s;
  logic          counts_clean_s;
`ifdef CMP_ONEHOT_CHECK_EN
  logic [CW-1:0] oh_cnt_r, oh_cnt_s;
  logic          oh_bad_s;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + CW'(1);
    end
  endfunction

  cmp_golden_model #(.W(W)) u_golden (
    .a     (a),
    .b     (b),
    .flags (exp_s)
  );

  always_comb begin
    obs_s         = 3'b000;
    obs_s[IDX_EQ] = eq;
    obs_s[IDX_GT] = gt;
    obs_s[IDX_LT] = lt;
  end

  // in_ready_r mirrors state RUN, so the handshake needs no decode of the state register
  assign accept_s   = in_valid & in_ready_r;
  assign mismatch_s = (obs_s != exp_s);
`ifdef CMP_ONEHOT_CHECK_EN
  assign oh_bad_s   = ~is_onehot3(obs_s);
`endif

  // Next-state, counter and capture logic feeding the output registers
  always_comb begin
    state_s      = state_r;
    vec_cnt_s    = vec_cnt_r;
    err_cnt_s    = err_cnt_r;
    fail_valid_s = fail_valid_r;
    fail_a_s     = fail_a_r;
    fail_b_s     = fail_b_r;
    fail_flags_s = fail_flags_r;
`ifdef CMP_ONEHOT_CHECK_EN
    oh_cnt_s     = oh_cnt_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s      = ST_RUN;
          vec_cnt_s    = {CW{1'b0}};
          err_cnt_s    = {CW{1'b0}};
          fail_valid_s = 1'b0;
          fail_a_s     = {W{1'b0}};
          fail_b_s     = {W{1'b0}};
          fail_flags_s = 3'b000;
`ifdef CMP_ONEHOT_CHECK_EN
          oh_cnt_s     = {CW{1'b0}};
`endif
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          vec_cnt_s = vec_cnt_r + CW'(1);
          if (mismatch_s) begin
            err_cnt_s = sat_inc(err_cnt_r);
            if (!fail_valid_r) begin
              fail_valid_s = 1'b1;
              fail_a_s     = a;
              fail_b_s     = b;
              fail_flags_s = obs_s;
            end else begin
              fail_valid_s = fail_valid_r;
            end
          end else begin
            err_cnt_s = err_cnt_r;
          end
`ifdef CMP_ONEHOT_CHECK_EN
          if (oh_bad_s) begin
            oh_cnt_s = sat_inc(oh_cnt_r);
          end else begin
            oh_cnt_s = oh_cnt_r;
          end
`endif
          if (vec_cnt_s == CW'(NUM_VEC)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

`ifdef CMP_ONEHOT_CHECK_EN
    counts_clean_s = (err_cnt_s == {CW{1'b0}}) && (oh_cnt_s == {CW{1'b0}});
`else
    counts_clean_s = (err_cnt_s == {CW{1'b0}});
`endif
    busy_s     = (state_s == ST_RUN);
    in_ready_s = (state_s == ST_RUN);
    done_s     = (state_s == ST_DONE);
    pass_s     = (state_s == ST_DONE) && counts_clean_s;
  end

  // Output and state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      in_ready_r   <= 1'b0;
      vec_cnt_r    <= {CW{1'b0}};
      err_cnt_r    <= {CW{1'b0}};
      fail_valid_r <= 1'b0;
      fail_a_r     <= {W{1'b0}};
      fail_b_r     <= {W{1'b0}};
      fail_flags_r <= 3'b000;
`ifdef CMP_ONEHOT_CHECK_EN
      oh_cnt_r     <= {CW{1'b0}};
`endif
    end else begin
      state_r      <= state_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      in_ready_r   <= in_ready_s;
      vec_cnt_r    <= vec_cnt_s;
      err_cnt_r    <= err_cnt_s;
      fail_valid_r <= fail_valid_s;
      fail_a_r     <= fail_a_s;
      fail_b_r     <= fail_b_s;
      fail_flags_r <= fail_flags_s;
`ifdef CMP_ONEHOT_CHECK_EN
      oh_cnt_r     <= oh_cnt_s;
`endif
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign in_ready   = in_ready_r;
  assign vec_cnt    = vec_cnt_r;
  assign err_cnt    = err_cnt_r;
  assign fail_valid = fail_valid_r;
  assign fail_a     = fail_a_r;
  assign fail_b     = fail_b_r;
  assign fail_flags = fail_flags_r;
`ifdef CMP_ONEHOT_CHECK_EN
  assign onehot_err_cnt = oh_cnt_r;
`endif

endmodule
